// File: rtl/ram_bist_pkg.sv
// Shared types and per-element constants for the 64x8 RAM March BIST.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } phase_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h55;

  typedef struct packed {
    logic down;    // 1 = address runs high to low
    logic rd_inv;  // expected read background is ~P
    logic wr_inv;  // write background is ~P
  } elem_t;

  function automatic elem_t elem_cfg(input state_e st);
    elem_t cfg;
    case (st)
      M0:      cfg = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0};
      M1:      cfg = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1};
      M2:      cfg = '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
      M3:      cfg = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b0};
      default: cfg = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/ram_bist_addr_ctr.sv
// Loadable up/down address counter; last flags the final address of the current direction.
module ram_bist_addr_ctr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;

  // Load the first address of the next element, otherwise step in the current direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
    end else if (load) begin
      addr_r <= load_down ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    end else if (step) begin
      addr_r <= down ? (addr_r - ONE) : (addr_r + ONE);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;
  assign last = down ? (addr_r == {ADDR_W{1'b0}}) : (addr_r == {ADDR_W{1'b1}});

endmodule

// File: rtl/ram_march_bist.sv
// March BIST initiator for a 64x8 async-read RAM: w(P)^, r(P)w(~P)^, r(~P)w(P)v, r(P)v.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  state_e            state_r, state_s;
  phase_e            phase_r, phase_s;
  logic              pass_r, pass_s;
  logic [ADDR_W-1:0] fail_addr_r, fail_addr_s;
  logic [DATA_W-1:0] fail_data_r, fail_data_s;

  logic              ctr_load_s, ctr_load_down_s, ctr_step_s;
  logic [ADDR_W-1:0] addr_s;
  logic              last_s;

  elem_t             cfg_s;
  logic              busy_s, rd_cycle_s, mismatch_s;
  logic [DATA_W-1:0] exp_s, wr_s;

  assign cfg_s      = elem_cfg(state_r);
  assign busy_s     = (state_r == M0) || (state_r == M1) || (state_r == M2) || (state_r == M3);
  assign exp_s      = cfg_s.rd_inv ? ~PATTERN : PATTERN;
  assign wr_s       = cfg_s.wr_inv ? ~PATTERN : PATTERN;
  assign rd_cycle_s = busy_s && (phase_r == RD);
  // Same-cycle compare: the RAM read is asynchronous, no pipeline stage
  assign mismatch_s = rd_cycle_s && (ram_data_out != exp_s);

  ram_bist_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load_s),
    .load_down (ctr_load_down_s),
    .step      (ctr_step_s),
    .down      (cfg_s.down),
    .addr      (addr_s),
    .last      (last_s)
  );

  // FSM state, phase and failure capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      phase_r     <= RD;
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      pass_r      <= pass_s;
      fail_addr_r <= fail_addr_s;
      fail_data_r <= fail_data_s;
    end
  end

  // Next-state, counter control and failure capture
  always_comb begin
    state_s         = state_r;
    phase_s         = phase_r;
    pass_s          = pass_r;
    fail_addr_s     = fail_addr_r;
    fail_data_s     = fail_data_r;
    ctr_load_s      = 1'b0;
    ctr_load_down_s = 1'b0;
    ctr_step_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s     = M0;
          phase_s     = WR;
          pass_s      = 1'b0;
          fail_addr_s = '0;
          fail_data_s = '0;
          ctr_load_s  = 1'b1;
        end else begin
          phase_s = RD;
        end
      end
      M0: begin
        if (last_s) begin
          state_s    = M1;
          phase_s    = RD;
          ctr_load_s = 1'b1;
        end else begin
          ctr_step_s = 1'b1;
        end
      end
      M1, M2: begin
        if (phase_r == RD) begin
          if (mismatch_s) begin
            // Abandon the element here; the pending write never happens
            state_s     = DONE;
            pass_s      = 1'b0;
            fail_addr_s = addr_s;
            fail_data_s = ram_data_out;
          end else begin
            phase_s = WR;
          end
        end else begin
          phase_s = RD;
          if (last_s) begin
            state_s         = (state_r == M1) ? M2 : M3;
            ctr_load_s      = 1'b1;
            ctr_load_down_s = 1'b1;
          end else begin
            ctr_step_s = 1'b1;
          end
        end
      end
      M3: begin
        if (mismatch_s) begin
          state_s     = DONE;
          pass_s      = 1'b0;
          fail_addr_s = addr_s;
          fail_data_s = ram_data_out;
        end else if (last_s) begin
          state_s = DONE;
          pass_s  = 1'b1;
        end else begin
          ctr_step_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        phase_s = RD;
      end
    endcase
  end

  assign busy        = busy_s;
  assign done        = (state_r == DONE);
  assign pass        = pass_r;
  assign fail_addr   = fail_addr_r;
  assign fail_data   = fail_data_r;
  assign ram_mode    = busy_s && (phase_r == WR);
  assign ram_addr    = busy_s ? addr_s : '0;
  assign ram_data_in = ram_mode ? wr_s : '0;

endmodule
